divider_seq: RTL
================

DIVIDER_SEQ -- requirements
Module: divider_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand, quotient and remainder width, legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: num1/num2 are valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block accepts an operation this cycle.
REQ-006 The block SHALL have ports num1 and num2, input, WIDTH bits each: num1 is the dividend, num2 the divisor.
REQ-007 The block SHALL have port out_valid, output, 1 bit: result, rest and div_zero are valid.
REQ-008 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-009 The block SHALL have ports result and rest, output, WIDTH bits each: quotient and remainder.
REQ-010 The block SHALL have port div_zero, output, 1 bit: the completed operation had num2 == 0.

Function
REQ-011 The block SHALL implement FSM states IDLE, BUSY and DONE, where in_ready = (state == IDLE) and out_valid = (state == DONE).
REQ-012 The block SHALL accept an operation on in_valid && in_ready, register num1 and num2, clear the accumulator and step counter, and then enter BUSY, or enter DONE if num2 == 0.
REQ-013 In BUSY, the block SHALL perform one restoring step per cycle: shift the accumulator left taking the dividend MSB, shift the quotient left, and if accumulator >= divisor, subtract the divisor and set quotient bit 0.
REQ-014 The block SHALL perform exactly WIDTH BUSY cycles, so out_valid rises WIDTH+1 cycles after the accept edge.
REQ-015 For num2 == 0, the block SHALL output result = all ones, rest = num1 and div_zero = 1, with out_valid one cycle after accept.
REQ-016 In DONE, the block SHALL hold result, rest and div_zero stable until out_valid && out_ready, then return to IDLE.
REQ-017 The block SHALL keep in_ready low in BUSY and DONE, and SHALL NOT accept a new operation in the same cycle a result is consumed.
REQ-018 When out_valid is low, result, rest and div_zero SHALL be 0.
REQ-019 In unsigned mode, the block SHALL satisfy num1 == result*num2 + rest with rest < num2, all arithmetic in WIDTH bits, and no internal overflow.

Reset
REQ-020 While rst is high at a clock edge, the block SHALL set state = IDLE, and set result, rest, div_zero, out_valid, the counter and the accumulator to 0; in_ready SHALL be 1 in the cycle after reset.
REQ-021 When rst is asserted in BUSY or DONE, the block SHALL abort the operation without producing out_valid, and SHALL discard the pending result.

Configuration
REQ-022 With macro DIVIDER_SIGNED_EN defined, the block SHALL add input signed_op (1 bit, sampled at accept) and SHALL treat operands as two's complement when signed_op = 1.
REQ-023 In signed mode, the block SHALL divide magnitudes, round the quotient toward zero, give the remainder the sign of the dividend, and for MIN/-1 return result = MIN, rest = 0.
REQ-024 In signed mode with divide-by-zero, the block SHALL return result = all ones, rest = num1 and div_zero = 1.
REQ-025 Without DIVIDER_SIGNED_EN, the block SHALL have no signed_op port, SHALL contain no sign logic, and SHALL be unsigned only.

Structure
REQ-026 Package divider_pkg SHALL hold the state enum (IDLE, BUSY, DONE) and the constant DIV_ZERO_QUOT_ALL_ONES.
REQ-027 Sub-module div_step SHALL be purely combinational: inputs are the accumulator, the dividend MSB and the divisor; outputs are the next accumulator and the quotient bit. divider_seq SHALL instantiate it once.

Verification
REQ-028 Unsigned case, WIDTH=8: num1=200, num2=7 -> result=28, rest=4, out_valid 9 cycles after accept.
REQ-029 Divide-by-zero case: num1=5, num2=0 -> result=0xFF, rest=5, div_zero=1, out_valid 1 cycle after accept.
REQ-030 Back-pressure case: 100/10 with out_ready held low for 3 cycles -> result=10 and rest=0 stay stable, in_ready=0 throughout, IDLE entered after the handshake.
REQ-031 Reset-mid-operation case: rst pulsed during BUSY cycle 4 -> no out_valid, next operation 255/16 -> result=15, rest=15.
REQ-032 Signed case (DIVIDER_SIGNED_EN, signed_op=1): -7/2 -> result=0xFD, rest=0xFF; -128/-1 -> result=0x80, rest=0.
REQ-033 Random case: 10k unsigned and signed operations against a reference model, including num1=0, num1<num2 and num2=1.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Quotient returned on divide-by-zero; sliced down to the operand width.
    localparam logic [31:0] DIV_ZERO_QUOT_ALL_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/divider_seq_if.sv
// Request/response bundle for divider_seq; signed_op exists only with DIVIDER_SIGNED_EN.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the operand and the result side.
interface divider_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] num1;
    logic [WIDTH-1:0] num2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] rest;
    logic             div_zero;
`ifdef DIVIDER_SIGNED_EN
    logic             signed_op;

    modport master (
        output in_valid, num1, num2, signed_op, out_ready,
        input  in_ready, out_valid, result, rest, div_zero
    );
    modport slave (
        input  in_valid, num1, num2, signed_op, out_ready,
        output in_ready, out_valid, result, rest, div_zero
    );
`else
    modport master (
        output in_valid, num1, num2, out_ready,
        input  in_ready, out_valid, result, rest, div_zero
    );
    modport slave (
        input  in_valid, num1, num2, out_ready,
        output in_ready, out_valid, result, rest, div_zero
    );
`endif
endinterface

// File: rtl/divider_seq_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract divisor if it fits.
// Latency: combinational.
// Backpressure: none.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic             msb_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] acc_o,
    output logic             q_o
);

    // One extra bit so the shifted partial remainder never wraps before the compare.
    logic [WIDTH:0] shifted;

    always_comb begin
        shifted = {acc_i, msb_i};
        q_o     = (shifted >= {1'b0, divisor_i});
        acc_o   = q_o ? (shifted[WIDTH-1:0] - divisor_i) : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/divider_seq.sv
// Sequential restoring divider, one quotient bit per cycle; signed mode via DIVIDER_SIGNED_EN.
// Latency: WIDTH+1 cycles from accept to out_valid, 1 cycle for divide-by-zero.
// Backpressure: result held in DONE until out_ready; in_ready low while BUSY or DONE.
module divider_seq
    import divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    divider_seq_if.slave io
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0] dvd_q,    dvd_d;
    logic [WIDTH-1:0] dvs_q,    dvs_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] rest_q,   rest_d;
    logic             dz_q,     dz_d;

    logic [WIDTH-1:0] step_acc;
    logic             step_q;
    logic [WIDTH-1:0] mag1, mag2;
    logic [WIDTH-1:0] quot_fin, rem_fin;

`ifdef DIVIDER_SIGNED_EN
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;
    logic n1_neg, n2_neg;

    always_comb begin
        n1_neg = io.signed_op & io.num1[WIDTH-1];
        n2_neg = io.signed_op & io.num2[WIDTH-1];
        mag1   = n1_neg ? -io.num1 : io.num1;
        mag2   = n2_neg ? -io.num2 : io.num2;
    end
`else
    always_comb begin
        mag1 = io.num1;
        mag2 = io.num2;
    end
`endif

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc_i    (acc_q),
        .msb_i    (dvd_q[WIDTH-1]),
        .divisor_i(dvs_q),
        .acc_o    (step_acc),
        .q_o      (step_q)
    );

    // The dividend register doubles as the quotient register: bits leave at the top
    // and quotient bits enter at the bottom, so after WIDTH steps it holds the quotient.
    always_comb begin
        quot_fin = {dvd_q[WIDTH-2:0], step_q};
        rem_fin  = step_acc;
`ifdef DIVIDER_SIGNED_EN
        if (qneg_q) quot_fin = -quot_fin;
        if (rneg_q) rem_fin  = -rem_fin;
`endif
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        rest_d   = rest_q;
        dz_d     = dz_q;
`ifdef DIVIDER_SIGNED_EN
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
`endif
        case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    acc_d = '0;
                    cnt_d = '0;
                    dvd_d = mag1;
                    dvs_d = mag2;
`ifdef DIVIDER_SIGNED_EN
                    qneg_d = n1_neg ^ n2_neg;
                    rneg_d = n1_neg;
`endif
                    if (io.num2 == '0) begin
                        state_d  = DONE;
                        result_d = DIV_ZERO_QUOT_ALL_ONES[WIDTH-1:0];
                        rest_d   = io.num1;
                        dz_d     = 1'b1;
                    end else begin
                        state_d  = BUSY;
                    end
                end
            end
            BUSY: begin
                acc_d = step_acc;
                dvd_d = {dvd_q[WIDTH-2:0], step_q};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d  = DONE;
                    result_d = quot_fin;
                    rest_d   = rem_fin;
                    dz_d     = 1'b0;
                end
            end
            DONE: begin
                if (io.out_ready) begin
                    state_d  = IDLE;
                    result_d = '0;
                    rest_d   = '0;
                    dz_d     = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            rest_q   <= '0;
            dz_q     <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            rest_q   <= rest_d;
            dz_q     <= dz_d;
`ifdef DIVIDER_SIGNED_EN
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
`endif
        end
    end

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = (state_q == DONE);
    assign io.result    = result_q;
    assign io.rest      = rest_q;
    assign io.div_zero  = dz_q;

endmodule
